apple1_dsp_uart_tx: RTL and testbench

Display back-end for the Apple-I/WozMon+PIA core. Consumes the `dsp_rdy`/`dsp_ack`/`dsp_data` character handshake driven by the display PIA and buffers characters in a small FIFO. Each character is serialised as 8N1 UART on `uart_tx`, so WozMon output reaches a host terminal without stalling the CPU on every byte.

---
 rtl/apple1_uart_pkg.sv | 22 ++
 rtl/dsp_fifo.sv | 56 +++++
 rtl/apple1_dsp_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_apple1_dsp_uart_tx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_uart_pkg.sv
// Shared types and constants for the Apple-I display UART back-end.
package apple1_uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  localparam logic [6:0] ASCII_CR = 7'h0D;
  localparam logic [6:0] ASCII_LF = 7'h0A;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_ACK,
    IN_WAIT_LOW
  } in_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/dsp_fifo.sv
// Synchronous FIFO for display characters; head entry is presented combinationally.
module dsp_fifo #(
  parameter int unsigned WIDTH   = 7,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [WIDTH-1:0]   i_wdata,
  output logic [WIDTH-1:0]   o_rdata,
  output logic [FIFO_AW:0]   o_count,
  output logic               o_full,
  output logic               o_empty
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == (FIFO_AW + 1)'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/apple1_dsp_uart_tx.sv
// Display PIA handshake -> FIFO -> 8N1 UART transmitter.
// Optional macro DSP_CR_LF_EN expands each captured CR into CR then LF.
module apple1_dsp_uart_tx
  import apple1_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_dsp_rdy,
  input  logic [6:0] i_dsp_data,
  output logic       o_dsp_ack,
  output logic       o_uart_tx,
  output logic       o_tx_busy,
  output logic       o_fifo_full
);

  localparam int unsigned TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam logic [TW-1:0]    BIT_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] ROOM_ONE = (FIFO_AW + 1)'(DEPTH - 1);

  in_state_e        r_in_state, w_in_state_next;
  tx_state_e        r_tx_state, w_tx_state_next;
  logic [TW-1:0]    r_timer, w_timer_next;
  logic [2:0]       r_bit_idx, w_bit_idx_next, w_bit_idx_inc;
  logic [7:0]       r_shift, w_shift_next;
  logic             r_uart_tx, w_uart_next;
  logic             w_push, w_pop, w_room, w_bit_done;
  logic [6:0]       w_wdata, w_fifo_rdata;
  logic [FIFO_AW:0] w_fifo_count;
  logic             w_fifo_full, w_fifo_empty;

  dsp_fifo #(
    .WIDTH  (7),
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_wdata(w_wdata),
    .o_rdata(w_fifo_rdata),
    .o_count(w_fifo_count),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

`ifdef DSP_CR_LF_EN
  localparam logic [FIFO_AW:0] ROOM_TWO = (FIFO_AW + 1)'(DEPTH - 2);
  logic r_lf_pend, w_lf_pend_next;

  // A CR needs two slots so the trailing LF can never hit a full FIFO.
  assign w_room = (i_dsp_data == ASCII_CR) ? (w_fifo_count <= ROOM_TWO)
                                           : (w_fifo_count <= ROOM_ONE);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_lf_pend <= 1'b0;
    else         r_lf_pend <= w_lf_pend_next;
  end
`else
  assign w_room = (w_fifo_count <= ROOM_ONE);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_in_state <= IN_IDLE;
    else         r_in_state <= w_in_state_next;
  end

  always_comb begin
    w_in_state_next = r_in_state;
    w_push          = 1'b0;
    w_wdata         = i_dsp_data;
    o_dsp_ack       = 1'b0;
`ifdef DSP_CR_LF_EN
    w_lf_pend_next  = r_lf_pend;
`endif
    case (r_in_state)
      IN_IDLE: begin
        if (i_dsp_rdy && w_room) begin
          w_push          = 1'b1;
          w_in_state_next = IN_ACK;
`ifdef DSP_CR_LF_EN
          w_lf_pend_next  = (i_dsp_data == ASCII_CR);
`endif
        end
      end
      IN_ACK: begin
`ifdef DSP_CR_LF_EN
        if (r_lf_pend) begin
          w_push         = 1'b1;
          w_wdata        = ASCII_LF;
          w_lf_pend_next = 1'b0;
        end else begin
          o_dsp_ack       = 1'b1;
          w_in_state_next = IN_WAIT_LOW;
        end
`else
        o_dsp_ack       = 1'b1;
        w_in_state_next = IN_WAIT_LOW;
`endif
      end
      IN_WAIT_LOW: begin
        if (!i_dsp_rdy) w_in_state_next = IN_IDLE;
      end
      default: w_in_state_next = IN_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_state <= TX_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_uart_tx  <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_timer    <= w_timer_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_uart_tx  <= w_uart_next;
    end
  end

  assign w_bit_done    = (r_timer == BIT_LAST);
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // Line level is computed for the next state so uart_tx stays a clean register.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_timer_next    = r_timer;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_uart_next     = r_uart_tx;
    w_pop           = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_uart_next = 1'b1;
        if (!w_fifo_empty) begin
          w_pop           = 1'b1;
          w_shift_next    = {1'b0, w_fifo_rdata};
          w_timer_next    = '0;
          w_uart_next     = 1'b0;
          w_tx_state_next = TX_START;
        end
      end
      TX_START: begin
        if (w_bit_done) begin
          w_timer_next    = '0;
          w_bit_idx_next  = '0;
          w_uart_next     = r_shift[0];
          w_tx_state_next = TX_DATA;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      TX_DATA: begin
        if (w_bit_done) begin
          w_timer_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_uart_next     = 1'b1;
            w_tx_state_next = TX_STOP;
          end else begin
            w_bit_idx_next = w_bit_idx_inc;
            w_uart_next    = r_shift[w_bit_idx_inc];
          end
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      TX_STOP: begin
        w_uart_next = 1'b1;
        if (w_bit_done) begin
          w_timer_next    = '0;
          w_tx_state_next = TX_IDLE;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  assign o_uart_tx   = r_uart_tx;
  assign o_tx_busy   = (r_tx_state != TX_IDLE) || !w_fifo_empty;
  assign o_fifo_full = w_fifo_full;

endmodule

// File: tb/tb_apple1_dsp_uart_tx.sv
// Scoreboard bench for apple1_dsp_uart_tx: a line monitor decodes frames, tasks compare them.
module tb_apple1_dsp_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rdy = 1'b0;
  logic [6:0] data = 7'h00;
  logic       ack, tx, busy, full;

  always #5 clk = ~clk;

  apple1_dsp_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (AW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_dsp_rdy  (rdy),
    .i_dsp_data (data),
    .o_dsp_ack  (ack),
    .o_uart_tx  (tx),
    .o_tx_busy  (busy),
    .o_fifo_full(full)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];
  int         rx_t[$];

  // Line monitor: frame = {stop, data[7:0], start}, sampled mid-bit.
  int         mon_st;
  logic [9:0] mon_bits;
  bit         mon_ab;
  always begin
    @(negedge clk);
    if (!reset && tx === 1'b0) begin
      mon_st   = cyc;
      mon_bits = '0;
      mon_ab   = 1'b0;
      for (int off = 1; off <= 38; off++) begin
        @(negedge clk);
        if (reset) mon_ab = 1'b1;
        if (off % 4 == 2) mon_bits[off/4] = tx;
      end
      if (!mon_ab) begin
        rx_q.push_back(mon_bits);
        rx_t.push_back(mon_st);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] frame_of(input logic [6:0] ch);
    return {1'b1, 1'b0, ch, 1'b0};
  endfunction

  task automatic push_exp(input logic [6:0] ch);
    exp_q.push_back(frame_of(ch));
`ifdef DSP_CR_LF_EN
    if (ch == 7'h0D) exp_q.push_back(frame_of(7'h0A));
`endif
  endtask

  function automatic logic [9:0] pop_exp();
    if (exp_q.size() == 0) return 10'bx;
    return exp_q.pop_front();
  endfunction

  task automatic drive_char(input logic [6:0] ch, input int hold, input int limit,
                            output int ack_cyc, output int n_acks);
    int i;
    @(negedge clk);
    rdy = 1'b1;
    data = ch;
    n_acks = 0;
    ack_cyc = -1;
    i = 0;
    while (i < limit && (n_acks == 0 || i < hold)) begin
      @(negedge clk);
      i++;
      if (ack) begin
        if (n_acks == 0) ack_cyc = cyc;
        n_acks++;
      end
    end
    rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (ack) n_acks++;
    end
  endtask

  task automatic get_frame(output logic [9:0] f, output int t, output bit ok);
    int i;
    i = 0;
    while (rx_q.size() == 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    if (rx_q.size() == 0) begin
      ok = 1'b0;
      f = 10'bx;
      t = -1;
    end else begin
      ok = 1'b1;
      f = rx_q.pop_front();
      t = rx_t.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack !== 1'b0)  begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_cmp++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_char();
    int a, n, t; logic [9:0] f, e; bit ok;
    push_exp(7'h41);
    drive_char(7'h41, 3, 50, a, n);
    n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL single_acks: got %0d want 1", n); end
    get_frame(f, t, ok);
    e = pop_exp();
    n_cmp++; if (!ok || f !== e) begin n_fail++; $display("FAIL single_frame: got %h want %h", f, e); end
    n_cmp++; if (t - a !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", t - a); end
    repeat (60) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_extra: frames %0d busy %b want 0 0", rx_q.size(), busy);
    end
  endtask

  task automatic test_ordering();
    logic [6:0] msg [5];
    int a, n, t, tp, i; logic [9:0] f, e; bit ok;
    msg[0] = 7'h48; msg[1] = 7'h45; msg[2] = 7'h4C; msg[3] = 7'h4C; msg[4] = 7'h4F;
    for (int k = 0; k < 5; k++) begin
      push_exp(msg[k]);
      drive_char(msg[k], 1, 200, a, n);
      n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL order_ack%0d: got %0d want 1", k, n); end
    end
    tp = -1;
    for (int k = 0; k < 5; k++) begin
      get_frame(f, t, ok);
      e = pop_exp();
      n_cmp++; if (!ok || f !== e) begin n_fail++; $display("FAIL order_frame%0d: got %h want %h", k, f, e); end
      if (k > 0) begin
        n_cmp++; if (t - tp !== 41) begin n_fail++; $display("FAIL order_gap%0d: got %0d want 41", k, t - tp); end
      end
      tp = t;
    end
    i = 0;
    while (busy && i < 200) begin @(negedge clk); i++; end
    n_cmp++; if (cyc - tp !== 40) begin n_fail++; $display("FAIL order_busy_fall: got %0d want 40", cyc - tp); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [6:0] ch [6];
    int a, n, t1, t2, a5, t; logic [9:0] f, e; bit ok;
    ch[0] = 7'h31; ch[1] = 7'h32; ch[2] = 7'h33; ch[3] = 7'h34; ch[4] = 7'h35; ch[5] = 7'h36;
    for (int k = 0; k < 5; k++) begin
      push_exp(ch[k]);
      drive_char(ch[k], 1, 50, a, n);
    end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL bp_full: got %b want 1", full); end
    push_exp(ch[5]);
    drive_char(ch[5], 1, 200, a5, n);
    n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL bp_ack5: got %0d want 1", n); end
    t1 = -1; t2 = -1;
    for (int k = 0; k < 6; k++) begin
      get_frame(f, t, ok);
      if (k == 0) t1 = t;
      if (k == 1) t2 = t;
      e = pop_exp();
      n_cmp++; if (!ok || f !== e) begin n_fail++; $display("FAIL bp_frame%0d: got %h want %h", k, f, e); end
    end
    n_cmp++; if (a5 - t2 < 0 || a5 - t2 > 2) begin
      n_fail++; $display("FAIL bp_ack_after_pop: got %0d cycles want 0..2", a5 - t2);
    end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_cr();
    int a, n, t, cnt; logic [9:0] f, e; bit ok;
    push_exp(7'h0D);
    drive_char(7'h0D, 2, 50, a, n);
    n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL cr_acks: got %0d want 1", n); end
    cnt = 0;
    while (exp_q.size() > 0) begin
      get_frame(f, t, ok);
      e = pop_exp();
      n_cmp++; if (!ok || f !== e) begin n_fail++; $display("FAIL cr_frame%0d: got %h want %h", cnt, f, e); end
      cnt++;
    end
    repeat (60) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL cr_extra: got %0d frames want 0", rx_q.size()); end
  endtask

  task automatic test_simul();
    int aa, ab, ac, n, ta, tb, tc, s; logic [9:0] f, e; bit ok;
    push_exp(7'h61); push_exp(7'h62); push_exp(7'h63);
    drive_char(7'h61, 1, 50, aa, n);
    drive_char(7'h62, 1, 50, ab, n);
    s = aa + 1;
    while (cyc < s + 39) @(negedge clk);
    drive_char(7'h63, 1, 50, ac, n);
    get_frame(f, ta, ok); e = pop_exp();
    n_cmp++; if (!ok || f !== e) begin n_fail++; $display("FAIL simul_frame0: got %h want %h", f, e); end
    get_frame(f, tb, ok); e = pop_exp();
    n_cmp++; if (!ok || f !== e) begin n_fail++; $display("FAIL simul_frame1: got %h want %h", f, e); end
    get_frame(f, tc, ok); e = pop_exp();
    n_cmp++; if (!ok || f !== e) begin n_fail++; $display("FAIL simul_frame2: got %h want %h", f, e); end
    n_cmp++; if (ac !== tb) begin n_fail++; $display("FAIL simul_same_edge: ack at %0d want %0d", ac, tb); end
    n_cmp++; if (tc - tb !== 41) begin n_fail++; $display("FAIL simul_gap: got %0d want 41", tc - tb); end
    repeat (60) @(negedge clk);
    n_cmp++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL simul_extra: got %0d frames want 0", rx_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int a, n, s, lows, acks;
    push_exp(7'h41); push_exp(7'h42); push_exp(7'h43);
    drive_char(7'h41, 1, 50, a, n);
    drive_char(7'h42, 1, 50, s, n);
    drive_char(7'h43, 1, 50, s, n);
    s = a + 1;
    while (cyc < s + 14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (ack !== 1'b0)  begin n_fail++; $display("FAIL rstmid_ack: got %b want 0", ack); end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    lows = 0; acks = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (ack !== 1'b0) acks++;
    end
    n_cmp++; if (lows !== 0 || acks !== 0) begin
      n_fail++; $display("FAIL rstmid_quiet: low cycles %0d acks %0d want 0 0", lows, acks);
    end
    n_cmp++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_frames: got %0d want 0", rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_ordering();
    test_backpressure();
    test_cr();
    test_simul();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
